wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 77 +++++++
 tb/tb_wb_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between write-back and a queued long-latency unit
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_pipe_we,
    input  logic [ADDR_W-1:0]             i_pipe_wra,
    input  logic [DATA_W-1:0]             i_pipe_data,
    input  logic                          i_lu_valid,
    input  logic [ADDR_W-1:0]             i_lu_wra,
    input  logic [DATA_W-1:0]             i_lu_data,
    output logic                          o_lu_ready,
    output logic                          o_pipe_stall,
    output logic                          o_regWe,
    output logic [ADDR_W-1:0]             o_WRA,
    output logic [DATA_W-1:0]             o_rstW,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1) + 1;

    logic [ADDR_W+DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]            r_wp, r_rp;
    logic [CW-1:0]            r_cnt;
    logic [SW-1:0]            r_starve;
    logic                     w_ready, w_push, w_ne, w_force, w_gf, w_gp;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [ADDR_W-1:0]        w_wra;
    logic [DATA_W-1:0]        w_data;

    always_comb begin
        w_ready      = r_cnt != CW'(FIFO_DEPTH);
        w_push       = i_lu_valid && w_ready;
        w_ne         = r_cnt != '0;
        w_force      = r_starve == SW'(STARVE_MAX);
        w_gf         = w_ne && (!i_pipe_we || w_force);
        w_gp         = i_pipe_we && !w_gf;
        w_head       = r_mem[r_rp];
        w_wra        = w_gf ? w_head[ADDR_W+DATA_W-1:DATA_W] : i_pipe_wra;
        w_data       = w_gf ? w_head[DATA_W-1:0] : i_pipe_data;
        o_lu_ready   = rst || w_ready;
        o_pipe_stall = !rst && i_pipe_we && w_gf;
        o_fifo_cnt   = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= {i_lu_wra, i_lu_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
            o_regWe  <= 1'b0;
            o_WRA    <= '0;
            o_rstW   <= '0;
        end else begin
            r_wp     <= r_wp + PW'(w_push);
            r_rp     <= r_rp + PW'(w_gf);
            r_cnt    <= r_cnt + CW'(w_push) - CW'(w_gf);
            r_starve <= (w_gf || !w_ne) ? '0 : (w_gp && !w_force) ? r_starve + 1'b1 : r_starve;
            o_regWe  <= (w_gf || w_gp) && w_wra != '0;
            if (w_gf || w_gp) begin
                o_WRA  <= w_wra;
                o_rstW <= w_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random stimulus checked against a queue-based reference model
module tb_wb_port_arbiter;
    localparam int DW = 32, AW = 5, D = 4, SM = 3;

    logic          clk = 1'b0, rst;
    logic          pipe_we, lu_valid;
    logic [AW-1:0] pipe_wra, lu_wra;
    logic [DW-1:0] pipe_data, lu_data;
    logic          lu_ready, pipe_stall, reg_we;
    logic [AW-1:0] wra;
    logic [DW-1:0] wdata;
    logic [2:0]    fifo_cnt;

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .i_pipe_we(pipe_we), .i_pipe_wra(pipe_wra), .i_pipe_data(pipe_data),
        .i_lu_valid(lu_valid), .i_lu_wra(lu_wra), .i_lu_data(lu_data),
        .o_lu_ready(lu_ready), .o_pipe_stall(pipe_stall),
        .o_regWe(reg_we), .o_WRA(wra), .o_rstW(wdata), .o_fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [AW+DW-1:0] q[$];
    int               starve;
    logic             m_we, last_stall;
    logic [AW-1:0]    m_wra;
    logic [DW-1:0]    m_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        pipe_we = pw; pipe_wra = pa; pipe_data = pd;
        lu_valid = lv; lu_wra = la; lu_data = ld;
    endtask

    task automatic cyc();
        bit ne, gf, gp, ins;
        logic [AW+DW-1:0] e;
        #1;
        ne = q.size() != 0;
        gf = ne && (!pipe_we || starve == SM);
        gp = pipe_we && !gf;
        last_stall = pipe_stall;
        chk("lu_ready", lu_ready, rst || q.size() < D);
        chk("stall", pipe_stall, !rst && pipe_we && gf);
        chk("cnt", fifo_cnt, q.size());
        chk("we", reg_we, m_we);
        chk("wra", wra, m_wra);
        chk("data", wdata, m_data);
        if (rst) begin
            q.delete(); starve = 0; m_we = 0; m_wra = 0; m_data = 0;
        end else begin
            ins = lu_valid && q.size() < D;
            if (gf) begin
                e = q.pop_front();
                {m_wra, m_data} = e;
                m_we = m_wra != 0;
            end else if (gp) begin
                m_wra = pipe_wra; m_data = pipe_data; m_we = pipe_wra != 0;
            end else m_we = 0;
            starve = (gf || !ne) ? 0 : gp ? (starve < SM ? starve + 1 : SM) : starve;
            if (ins) q.push_back({lu_wra, lu_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] pat;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        q.delete(); starve = 0; m_we = 0; m_wra = 0; m_data = 0;
        rst = 1'b0;
        chk("rst_ready", lu_ready, 1);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_we", reg_we, 0);

        drive(1, 5, 32'h1234, 0, 0, 0); cyc();
        chk("pipe_only_we", reg_we, 1);
        chk("pipe_only_wra", wra, 5);
        chk("pipe_only_data", wdata, 32'h1234);
        chk("pipe_only_stall", last_stall, 0);

        drive(0, 0, 0, 1, 7, 32'hBEEF); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc();
        chk("queued_we", reg_we, 1);
        chk("queued_wra", wra, 7);
        chk("queued_data", wdata, 32'hBEEF);
        chk("queued_cnt", fifo_cnt, 0);

        drive(1, 3, 32'h11, 1, 9, 32'h99); cyc();
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(i + 1), 32'(i), 0, 0, 0);
            cyc();
            pat[i] = last_stall;
        end
        chk("starve_pattern", pat, 5'b01000);

        for (int i = 0; i < 4; i++) begin
            drive(starve < SM, 2, 32'(i), 1, 5'(10 + i), 32'(100 + i));
            cyc();
        end
        drive(starve < SM, 2, 0, 1, 14, 114);
        #1;
        chk("fill_cnt", fifo_cnt, 4);
        chk("fill_ready", lu_ready, 0);
        cyc();
        chk("fill_pop_wra", wra, 10);
        chk("fill_ready_after", lu_ready, 1);
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0); cyc();
            chk("fill_order", wra, 5'(10 + i));
        end

        drive(1, 0, 32'h55, 0, 0, 0); cyc();
        chk("r0_pipe_we", reg_we, 0);
        drive(0, 0, 0, 1, 0, 32'h77); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc();
        chk("r0_fifo_we", reg_we, 0);
        chk("r0_fifo_cnt", fifo_cnt, 0);

        for (int i = 0; i < 3; i++) begin
            drive(1, 4, 32'(i), 1, 5'(20 + i), 32'(200 + i)); cyc();
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrst_cnt", fifo_cnt, 0);
        chk("midrst_we", reg_we, 0);
        chk("midrst_ready", lu_ready, 1);
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) cyc();

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(99) == 0;
            drive($urandom_range(9) < 6, 5'($urandom_range(3) == 0 ? 0 : $urandom),
                  $urandom, $urandom_range(9) < 4, 5'($urandom_range(4) == 0 ? 0 : $urandom), $urandom);
            cyc();
        end
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
